bcd_counter_ndigit: RTL and testbench

//   Parametrised N-digit BCD up/down counter for scoreboard/display paths.

---
 rtl/bcd_counter_ndigit.sv | 128 ++++++++++++
 tb/tb_bcd_counter_ndigit.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/bcd_counter_ndigit.sv
// N-digit BCD up/down counter with parallel load, erase and wrap/saturate
// behaviour at the limits.
// Optional feature macro: BCD_CNT_LOAD_CHECK_EN.
//   When it is defined, a load with any nibble >9 is rejected and err_o pulses.
//   When it is undefined, such nibbles are clamped to 9 and err_o is tied 0.
module bcd_counter_ndigit #(
  parameter int DIGITS   = 4,
  parameter int SATURATE = 0
) (
  input  logic                  clk,
  input  logic                  rst_i,
  input  logic                  erase_i,
  input  logic                  load_i,
  input  logic [4*DIGITS-1:0]   load_val_i,
  input  logic                  inc_i,
  input  logic                  dec_i,
  output logic [4*DIGITS-1:0]   count_o,
  output logic                  carry_o,
  output logic                  borrow_o,
  output logic                  zero_o,
  output logic                  max_o,
  output logic                  err_o
);

  localparam logic [4*DIGITS-1:0] ALL_NINES = {DIGITS{4'h9}};

  logic [4*DIGITS-1:0] count_q, count_d;
  logic                carry_q, carry_d;
  logic                borrow_q, borrow_d;
  logic                err_q, err_d;

  logic [4*DIGITS-1:0] inc_val, dec_val, load_fixed;
  logic                load_bad;
  logic                at_zero, at_max;

  assign at_zero = (count_q == '0);
  assign at_max  = (count_q == ALL_NINES);

  // Ripple increment/decrement across all digits, and screen the load value.
  always_comb begin
    logic ci;
    logic bi;
    logic [3:0] nib;
    inc_val    = count_q;
    dec_val    = count_q;
    load_fixed = load_val_i;
    load_bad   = 1'b0;
    ci         = 1'b1;
    bi         = 1'b1;
    for (int k = 0; k < DIGITS; k++) begin
      nib = count_q[4*k +: 4];
      if (ci) begin
        if (nib == 4'd9) begin
          inc_val[4*k +: 4] = 4'd0;
        end else begin
          inc_val[4*k +: 4] = nib + 4'd1;
          ci = 1'b0;
        end
      end
      if (bi) begin
        if (nib == 4'd0) begin
          dec_val[4*k +: 4] = 4'd9;
        end else begin
          dec_val[4*k +: 4] = nib - 4'd1;
          bi = 1'b0;
        end
      end
      if (load_val_i[4*k +: 4] > 4'd9) begin
        load_bad = 1'b1;
        load_fixed[4*k +: 4] = 4'd9;
      end
    end
  end

  // Next-state selection in priority order erase > load > inc/dec.
  always_comb begin
    count_d  = count_q;
    carry_d  = 1'b0;
    borrow_d = 1'b0;
    err_d    = 1'b0;
    if (erase_i) begin
      count_d = '0;
    end else if (load_i) begin
`ifdef BCD_CNT_LOAD_CHECK_EN
      if (load_bad) begin
        err_d = 1'b1;
      end else begin
        count_d = load_val_i;
      end
`else
      count_d = load_fixed;
`endif
    end else if (inc_i && !dec_i) begin
      carry_d = at_max;
      if (!(at_max && (SATURATE != 0))) begin
        count_d = inc_val;
      end
    end else if (dec_i && !inc_i) begin
      borrow_d = at_zero;
      if (!(at_zero && (SATURATE != 0))) begin
        count_d = dec_val;
      end
    end
  end

  // Count register and single-cycle status pulses.
  always_ff @(posedge clk) begin
    if (rst_i) begin
      count_q  <= '0;
      carry_q  <= 1'b0;
      borrow_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      count_q  <= count_d;
      carry_q  <= carry_d;
      borrow_q <= borrow_d;
      err_q    <= err_d;
    end
  end

  assign count_o  = count_q;
  assign carry_o  = carry_q;
  assign borrow_o = borrow_q;
  assign zero_o   = at_zero;
  assign max_o    = at_max;
  assign err_o    = err_q;

endmodule

// File: tb/tb_bcd_counter_ndigit.sv
// Directed testbench: one wrapping and one saturating 4-digit counter
// share the same stimulus.
`timescale 1ns/1ps
module tb_bcd_counter_ndigit;

  logic        clk = 1'b0;
  logic        rst_i = 1'b0, erase_i = 1'b0, load_i = 1'b0, inc_i = 1'b0, dec_i = 1'b0;
  logic [15:0] load_val_i = 16'h0;

  logic [15:0] cnt_w, cnt_s;
  logic        car_w, bor_w, zer_w, max_w, err_w;
  logic        car_s, bor_s, zer_s, max_s, err_s;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  bcd_counter_ndigit #(.DIGITS(4), .SATURATE(0)) u_wrap (
    .clk(clk), .rst_i(rst_i), .erase_i(erase_i), .load_i(load_i),
    .load_val_i(load_val_i), .inc_i(inc_i), .dec_i(dec_i),
    .count_o(cnt_w), .carry_o(car_w), .borrow_o(bor_w),
    .zero_o(zer_w), .max_o(max_w), .err_o(err_w));

  bcd_counter_ndigit #(.DIGITS(4), .SATURATE(1)) u_sat (
    .clk(clk), .rst_i(rst_i), .erase_i(erase_i), .load_i(load_i),
    .load_val_i(load_val_i), .inc_i(inc_i), .dec_i(dec_i),
    .count_o(cnt_s), .carry_o(car_s), .borrow_o(bor_s),
    .zero_o(zer_s), .max_o(max_s), .err_o(err_s));

  task automatic tick();
    @(posedge clk);
    #1;
    rst_i = 0; erase_i = 0; load_i = 0; inc_i = 0; dec_i = 0;
  endtask

  task automatic do_load(input logic [15:0] v);
    load_i = 1; load_val_i = v;
    tick();
  endtask

  task automatic test_reset();
    rst_i = 1; inc_i = 1;
    tick();
    checks++; if (cnt_w !== 16'h0000) begin errors++; $display("FAIL reset_count_w got %h exp 0000", cnt_w); end
    checks++; if (cnt_s !== 16'h0000) begin errors++; $display("FAIL reset_count_s got %h exp 0000", cnt_s); end
    checks++; if ({zer_w, max_w} !== 2'b10) begin errors++; $display("FAIL reset_zero_max got %b exp 10", {zer_w, max_w}); end
    checks++; if ({car_w, bor_w, err_w, car_s, bor_s, err_s} !== 6'b0) begin errors++; $display("FAIL reset_pulses got %b exp 000000", {car_w, bor_w, err_w, car_s, bor_s, err_s}); end
  endtask

  task automatic test_inc_ripple();
    do_load(16'h0999);
    inc_i = 1; tick();
    checks++; if (cnt_w !== 16'h1000) begin errors++; $display("FAIL inc_ripple got %h exp 1000", cnt_w); end
    checks++; if (car_w !== 1'b0) begin errors++; $display("FAIL inc_ripple_carry got %b exp 0", car_w); end
    do_load(16'h0019);
    inc_i = 1; tick();
    checks++; if (cnt_w !== 16'h0020) begin errors++; $display("FAIL inc_units_roll got %h exp 0020", cnt_w); end
    do_load(16'h9999);
    checks++; if ({max_w, zer_w} !== 2'b10) begin errors++; $display("FAIL max_flag got %b exp 10", {max_w, zer_w}); end
    inc_i = 1; tick();
    checks++; if (cnt_w !== 16'h0000 || car_w !== 1'b1) begin errors++; $display("FAIL inc_wrap got %h/%b exp 0000/1", cnt_w, car_w); end
    checks++; if (zer_w !== 1'b1) begin errors++; $display("FAIL inc_wrap_zero got %b exp 1", zer_w); end
    tick();
    checks++; if (cnt_w !== 16'h0000 || car_w !== 1'b0) begin errors++; $display("FAIL carry_one_cycle got %h/%b exp 0000/0", cnt_w, car_w); end
  endtask

  task automatic test_dec_wrap();
    erase_i = 1; tick();
    dec_i = 1; tick();
    checks++; if (cnt_w !== 16'h9999 || bor_w !== 1'b1 || max_w !== 1'b1) begin errors++; $display("FAIL dec_wrap got %h/%b/%b exp 9999/1/1", cnt_w, bor_w, max_w); end
    checks++; if (cnt_s !== 16'h0000 || bor_s !== 1'b1 || zer_s !== 1'b1) begin errors++; $display("FAIL dec_sat got %h/%b/%b exp 0000/1/1", cnt_s, bor_s, zer_s); end
    dec_i = 1; tick();
    checks++; if (cnt_w !== 16'h9998 || bor_w !== 1'b0) begin errors++; $display("FAIL dec_second got %h/%b exp 9998/0", cnt_w, bor_w); end
    checks++; if (cnt_s !== 16'h0000 || bor_s !== 1'b1) begin errors++; $display("FAIL dec_sat_again got %h/%b exp 0000/1", cnt_s, bor_s); end
    do_load(16'h1000);
    dec_i = 1; tick();
    checks++; if (cnt_w !== 16'h0999 || bor_w !== 1'b0) begin errors++; $display("FAIL dec_ripple got %h/%b exp 0999/0", cnt_w, bor_w); end
  endtask

  task automatic test_saturate();
    logic [15:0] exp_w [3];
    exp_w[0] = 16'h0000; exp_w[1] = 16'h0001; exp_w[2] = 16'h0002;
    do_load(16'h9999);
    for (int i = 0; i < 3; i++) begin
      inc_i = 1; tick();
      checks++; if (cnt_s !== 16'h9999 || car_s !== 1'b1) begin errors++; $display("FAIL sat_hold_%0d got %h/%b exp 9999/1", i, cnt_s, car_s); end
      checks++; if (cnt_w !== exp_w[i] || car_w !== (i == 0)) begin errors++; $display("FAIL wrap_seq_%0d got %h/%b exp %h/%b", i, cnt_w, car_w, exp_w[i], (i == 0)); end
    end
  endtask

  task automatic test_priority();
    do_load(16'h0042);
    inc_i = 1; dec_i = 1; tick();
    checks++; if (cnt_w !== 16'h0042 || car_w !== 1'b0 || bor_w !== 1'b0) begin errors++; $display("FAIL inc_dec_hold got %h/%b%b exp 0042/00", cnt_w, car_w, bor_w); end
    erase_i = 1; inc_i = 1; tick();
    checks++; if (cnt_w !== 16'h0000) begin errors++; $display("FAIL erase_over_inc got %h exp 0000", cnt_w); end
    load_i = 1; load_val_i = 16'h1234; dec_i = 1; tick();
    checks++; if (cnt_w !== 16'h1234 || bor_w !== 1'b0) begin errors++; $display("FAIL load_over_dec got %h/%b exp 1234/0", cnt_w, bor_w); end
    do_load(16'h9999);
    erase_i = 1; inc_i = 1; tick();
    checks++; if (cnt_s !== 16'h0000 || car_s !== 1'b0 || car_w !== 1'b0) begin errors++; $display("FAIL erase_no_carry got %h/%b%b exp 0000/00", cnt_s, car_s, car_w); end
    do_load(16'h0000);
    load_i = 1; load_val_i = 16'h5555; erase_i = 1; tick();
    checks++; if (cnt_w !== 16'h0000) begin errors++; $display("FAIL erase_over_load got %h exp 0000", cnt_w); end
    rst_i = 1; load_i = 1; load_val_i = 16'h7777; tick();
    checks++; if (cnt_w !== 16'h0000) begin errors++; $display("FAIL rst_over_load got %h exp 0000", cnt_w); end
  endtask

  task automatic test_load_check();
    do_load(16'h1234);
    do_load(16'h12A4);
`ifdef BCD_CNT_LOAD_CHECK_EN
    checks++; if (cnt_w !== 16'h1234 || err_w !== 1'b1) begin errors++; $display("FAIL load_reject got %h/%b exp 1234/1", cnt_w, err_w); end
`else
    checks++; if (cnt_w !== 16'h1294 || err_w !== 1'b0) begin errors++; $display("FAIL load_clamp got %h/%b exp 1294/0", cnt_w, err_w); end
`endif
    do_load(16'h0567);
    checks++; if (cnt_w !== 16'h0567 || err_w !== 1'b0) begin errors++; $display("FAIL load_valid got %h/%b exp 0567/0", cnt_w, err_w); end
`ifndef BCD_CNT_LOAD_CHECK_EN
    do_load(16'hFBC3);
    checks++; if (cnt_w !== 16'h9993) begin errors++; $display("FAIL load_clamp_multi got %h exp 9993", cnt_w); end
`endif
  endtask

  task automatic test_back_to_back();
    int n;
    logic [15:0] exp_bcd;
    erase_i = 1; tick();
    for (int i = 1; i <= 25; i++) begin
      inc_i = 1; tick();
      n = i;
      exp_bcd = {4'(n / 1000), 4'((n / 100) % 10), 4'((n / 10) % 10), 4'(n % 10)};
      if (i % 5 == 0) begin
        checks++; if (cnt_w !== exp_bcd) begin errors++; $display("FAIL b2b_inc_%0d got %h exp %h", i, cnt_w, exp_bcd); end
      end
    end
  endtask

  initial begin
    #2;
    test_reset();
    test_inc_ripple();
    test_dec_wrap();
    test_saturate();
    test_priority();
    test_load_check();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
